// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types and constants for the IF-stage fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT       = 2'd0,
        S_FETCH      = 2'd1,
        S_REDIR_WAIT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_PEND   = 2'd3
    } pc_sel_t;

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_fetch_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_controller_if
//  Description : Hazard/branch inputs and IMEM/IF-ID outputs of the fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_controller_if #(
    parameter int XLEN = 32
);
    logic            IMEM_BUSYWAIT;
    logic            STALL;
    logic            REDIRECT;
    logic [XLEN-1:0] REDIRECT_TARGET;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC_PLUS4;
    logic            IMEM_READ;
    logic [XLEN-1:0] IMEM_ADDRESS;
    logic            IFID_WRITE;
    logic            IFID_FLUSH;

    modport master (
        input  IMEM_BUSYWAIT, STALL, REDIRECT, REDIRECT_TARGET,
        output PC, PC_PLUS4, IMEM_READ, IMEM_ADDRESS, IFID_WRITE, IFID_FLUSH
    );

    modport slave (
        output IMEM_BUSYWAIT, STALL, REDIRECT, REDIRECT_TARGET,
        input  PC, PC_PLUS4, IMEM_READ, IMEM_ADDRESS, IFID_WRITE, IFID_FLUSH
    );
endinterface : pc_fetch_controller_if
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_next_pc
//  Description : Combinational next-PC mux (hold / sequential / redirect / pending).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_target,
    input  wire logic [XLEN-1:0] i_pend,
    input  wire pc_sel_t         i_sel,
    output logic      [XLEN-1:0] o_next_pc,
    output logic      [XLEN-1:0] o_pc_plus4
);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] w_target_aligned;

    // Wraps naturally at 2^XLEN.
    assign o_pc_plus4       = i_pc + XLEN'(INSTR_BYTES);
    assign w_target_aligned = i_target & C_ALIGN_MASK;

    always_comb begin
        o_next_pc = i_pc;
        case (i_sel)
            SEL_HOLD:   o_next_pc = i_pc;
            SEL_SEQ:    o_next_pc = o_pc_plus4;
            SEL_TARGET: o_next_pc = w_target_aligned;
            SEL_PEND:   o_next_pc = i_pend;
            default:    o_next_pc = i_pc;
        endcase
    end
endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/pc_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_controller
//  Description : IF-stage PC sequencer, IMEM read handshake and IF/ID control.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    pc_fetch_controller_if.master fetch
);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    pc_sel_t         w_sel;
    logic            w_pend_load;
    logic            w_imem_read;
    logic            w_ifid_write;
    logic            w_ifid_flush;

    fetch_next_pc #(
        .XLEN (XLEN)
    ) u_next_pc (
        .i_pc       (r_pc),
        .i_target   (fetch.REDIRECT_TARGET),
        .i_pend     (r_pend_target),
        .i_sel      (w_sel),
        .o_next_pc  (w_next_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_next_pc;
            if (w_pend_load) begin
                r_pend_target <= fetch.REDIRECT_TARGET & C_ALIGN_MASK;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel        = SEL_HOLD;
        w_pend_load  = 1'b0;
        w_imem_read  = 1'b0;
        w_ifid_write = 1'b0;
        w_ifid_flush = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_ifid_flush = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_FETCH: begin
                w_imem_read = 1'b1;
                if (fetch.REDIRECT && !fetch.IMEM_BUSYWAIT) begin
                    w_sel        = SEL_TARGET;
                    w_ifid_flush = 1'b1;
                end else if (fetch.REDIRECT) begin
                    w_pend_load = 1'b1;
                    w_state_nxt = S_REDIR_WAIT;
                end else if (!fetch.IMEM_BUSYWAIT && !fetch.STALL) begin
                    w_sel        = SEL_SEQ;
                    w_ifid_write = 1'b1;
                end
            end
            S_REDIR_WAIT: begin
                // The wrong-path fetch must drain; only the latest redirect survives.
                w_imem_read = 1'b1;
                if (fetch.IMEM_BUSYWAIT) begin
                    w_pend_load = fetch.REDIRECT;
                end else begin
                    w_sel        = fetch.REDIRECT ? SEL_TARGET : SEL_PEND;
                    w_ifid_flush = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
        if (RESET) begin
            w_imem_read  = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    assign fetch.PC           = r_pc;
    assign fetch.PC_PLUS4     = w_pc_plus4;
    assign fetch.IMEM_ADDRESS = r_pc;
    assign fetch.IMEM_READ    = w_imem_read;
    assign fetch.IFID_WRITE   = w_ifid_write;
    assign fetch.IFID_FLUSH   = w_ifid_flush;
endmodule : pc_fetch_controller
`default_nettype wire
